// File: rtl/rggen_indirect_register_array.sv
// Indirect register array: an INDEX word selects which storage entry the DATA window reaches.
// Optional RGGEN_INDIRECT_ARRAY_AUTO_INC_EN advances INDEX after every successful DATA access.
module rggen_indirect_register_array #(
  parameter int                       ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter int                       BUS_WIDTH      = 32,
  parameter int                       VALUE_WIDTH    = 32,
  parameter int                       ENTRIES        = 4,
  parameter int                       INDEX_WIDTH    = 8,
  parameter logic [VALUE_WIDTH-1:0]   INITIAL_VALUE  = '0
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic                           i_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_address,
  input  logic [BUS_WIDTH-1:0]           i_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_strobe,
  output logic                           o_ready,
  output logic [1:0]                     o_status,
  output logic [BUS_WIDTH-1:0]           o_read_data,
  output logic [INDEX_WIDTH-1:0]         o_index,
  output logic [ENTRIES*VALUE_WIDTH-1:0] o_value,
  input  logic                           i_hw_write,
  input  logic [INDEX_WIDTH-1:0]         i_hw_index,
  input  logic [VALUE_WIDTH-1:0]         i_hw_data
);

  localparam int                       BYTES        = BUS_WIDTH / 8;
  localparam int                       LSB          = $clog2(BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS = OFFSET_ADDRESS + ADDRESS_WIDTH'(BYTES);
  localparam logic [INDEX_WIDTH:0]     ENTRY_COUNT  = (INDEX_WIDTH + 1)'(ENTRIES);
  localparam logic [1:0]               OKAY         = 2'b00;
  localparam logic [1:0]               SLAVE_ERROR  = 2'b10;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t                                state;
  logic                                  ready;
  logic [1:0]                            status;
  logic [BUS_WIDTH-1:0]                  read_data;
  logic [INDEX_WIDTH-1:0]                index;
  logic [ENTRIES-1:0][VALUE_WIDTH-1:0]   entry;

  logic [BUS_WIDTH-1:0]                  bit_mask;
  logic                                  hit_index;
  logic                                  hit_data;
  logic                                  index_ok;
  logic                                  access;
  logic                                  data_write;
  logic [VALUE_WIDTH-1:0]                read_value;
  logic [INDEX_WIDTH-1:0]                index_next;
  logic [ENTRIES-1:0][VALUE_WIDTH-1:0]   entry_next;
  logic [1:0]                            resp_status;
  logic [BUS_WIDTH-1:0]                  resp_data;
  logic                                  unused_bits;

  assign hit_index  = i_address[ADDRESS_WIDTH-1:LSB] == OFFSET_ADDRESS[ADDRESS_WIDTH-1:LSB];
  assign hit_data   = i_address[ADDRESS_WIDTH-1:LSB] == DATA_ADDRESS[ADDRESS_WIDTH-1:LSB];
  assign index_ok   = {1'b0, index} < ENTRY_COUNT;
  assign access     = (state == IDLE) && i_valid;
  assign data_write = access && i_write && hit_data && index_ok;

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      bit_mask[8*b +: 8] = {8{i_strobe[b]}};
    end
  end

  always_comb begin
    read_value = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (index == INDEX_WIDTH'(k)) begin
        read_value = entry[k];
      end
    end
  end

  // Hardware data lands first; strobed bus bytes then override it on a collision.
  always_comb begin
    entry_next = entry;
    for (int k = 0; k < ENTRIES; k++) begin
      if (i_hw_write && (i_hw_index == INDEX_WIDTH'(k))) begin
        entry_next[k] = i_hw_data;
      end
      if (data_write && (index == INDEX_WIDTH'(k))) begin
        entry_next[k] = (entry_next[k] & ~bit_mask[VALUE_WIDTH-1:0])
                      | (i_write_data[VALUE_WIDTH-1:0] & bit_mask[VALUE_WIDTH-1:0]);
      end
    end
  end

  always_comb begin
    index_next = index;
    if (access && i_write && hit_index) begin
      index_next = (index & ~bit_mask[INDEX_WIDTH-1:0])
                 | (i_write_data[INDEX_WIDTH-1:0] & bit_mask[INDEX_WIDTH-1:0]);
    end
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
    else if (access && hit_data && index_ok) begin
      if (({1'b0, index} + (INDEX_WIDTH + 1)'(1)) == ENTRY_COUNT) begin
        index_next = '0;
      end else begin
        index_next = index + INDEX_WIDTH'(1);
      end
    end
`endif
  end

  always_comb begin
    resp_status = SLAVE_ERROR;
    resp_data   = '0;
    if (hit_index) begin
      resp_status = OKAY;
      if (!i_write) begin
        resp_data = BUS_WIDTH'(index);
      end
    end else if (hit_data && index_ok) begin
      resp_status = OKAY;
      if (!i_write) begin
        resp_data = BUS_WIDTH'(read_value);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      status    <= OKAY;
      read_data <= '0;
      index     <= '0;
      entry     <= {ENTRIES{INITIAL_VALUE}};
    end else begin
      entry <= entry_next;
      index <= index_next;
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (i_valid) begin
            ready     <= 1'b1;
            status    <= resp_status;
            read_data <= resp_data;
            state     <= RESP;
          end
        end
        RESP: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A reset arriving during the response cycle suppresses the strobe immediately.
  assign o_ready     = ready & ~i_rst;
  assign o_status    = status;
  assign o_read_data = read_data;
  assign o_index     = index;
  assign o_value     = entry;

  assign unused_bits = ^{i_address, i_write_data, i_strobe};

endmodule

// File: tb/tb_rggen_indirect_register_array.sv
// Bench for rggen_indirect_register_array: directed table, corner sequences, randomized run vs a model.
module tb_rggen_indirect_register_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         write;
  logic [7:0]   address;
  logic [31:0]  wdata;
  logic [3:0]   strobe;
  logic         ready;
  logic [1:0]   status;
  logic [31:0]  rdata;
  logic [7:0]   index;
  logic [127:0] value;
  logic         hw_write;
  logic [7:0]   hw_index;
  logic [31:0]  hw_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_entry [4];
  logic [7:0]  m_index;

  always #5 clk = ~clk;

  rggen_indirect_register_array dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_write      (write),
    .i_address    (address),
    .i_write_data (wdata),
    .i_strobe     (strobe),
    .o_ready      (ready),
    .o_status     (status),
    .o_read_data  (rdata),
    .o_index      (index),
    .o_value      (value),
    .i_hw_write   (hw_write),
    .i_hw_index   (hw_index),
    .i_hw_data    (hw_data)
  );

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          he;
    logic [7:0]  hi;
    logic [31:0] hd;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_entry[k] = 32'h0;
    m_index = 8'h0;
  endtask

  // Reference behaviour straight from the address map rules.
  task automatic model_txn(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit he, input logic [7:0] hi, input logic [31:0] hd,
                           output logic [1:0] st, output logic [31:0] rd);
    logic [31:0] pre [4];
    int word;
    int idx;
    word = int'(a) / 4;
    idx  = int'(m_index);
    pre  = m_entry;
    st   = 2'b10;
    rd   = 32'h0;
    if (he && int'(hi) < 4) m_entry[int'(hi)] = hd;
    if (word == 0) begin
      st = 2'b00;
      if (!w) rd = {24'h0, m_index};
      else if (s[0]) m_index = d[7:0];
    end else if (word == 1 && idx < 4) begin
      st = 2'b00;
      if (!w) rd = pre[idx];
      else for (int b = 0; b < 4; b++) if (s[b]) m_entry[idx][8*b +: 8] = d[8*b +: 8];
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
      m_index = (idx + 1 == 4) ? 8'h0 : 8'(idx + 1);
`endif
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " o_index"}, {24'h0, index}, {24'h0, m_index});
    for (int k = 0; k < 4; k++)
      check($sformatf("%s entry%0d", tag, k), value[32*k +: 32], m_entry[k]);
  endtask

  task automatic txn(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit he, input logic [7:0] hi, input logic [31:0] hd,
                     output logic [1:0] st, output logic [31:0] rd,
                     output logic [1:0] mst, output logic [31:0] mrd);
    int n;
    @(negedge clk);
    valid = 1'b1; write = w; address = a; wdata = d; strobe = s;
    hw_write = he; hw_index = hi; hw_data = hd;
    model_txn(w, a, d, s, he, hi, hd, mst, mrd);
    n = 0;
    do begin
      @(posedge clk); #1;
      hw_write = 1'b0;
      n++;
    end while (!ready && n < 8);
    check("latency", n, 1);
    st = status;
    rd = rdata;
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'h0, ready}, 32'h0);
    check_state("post_txn");
  endtask

  task automatic add(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit he, input logic [7:0] hi, input logic [31:0] hd,
                     input logic [1:0] est, input logic [31:0] erd);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.he = he; v.hi = hi; v.hd = hd;
    v.exp_st = est; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0]  st, mst;
    logic [31:0] rd, mrd;
    logic [7:0]  ra;
    int          pick;

    rst = 1'b1; valid = 1'b0; write = 1'b0; address = '0; wdata = '0; strobe = '0;
    hw_write = 1'b0; hw_index = '0; hw_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset o_ready", {31'h0, ready}, 32'h0);
    check("reset o_status", {30'h0, status}, 32'h0);
    check("reset o_read_data", rdata, 32'h0);
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    //   w   addr   wdata         strb   hw hidx   hdata         status  rdata
    add(0, 8'h00, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h00, 32'h2,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h04, 32'hDEADBEEF, 4'h3, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h00, 32'h2,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h0000BEEF);
    add(1, 8'h00, 32'h4,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h04, 32'h12345678, 4'hF, 0, 8'd0, 32'h0,        2'b10, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b10, 32'h0);
    add(0, 8'h08, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b10, 32'h0);
    add(1, 8'h0C, 32'h0,        4'hF, 0, 8'd0, 32'h0,        2'b10, 32'h0);
    add(0, 8'h00, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h4);
    add(1, 8'h00, 32'h1,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h04, 32'h11223344, 4'h1, 1, 8'd1, 32'hAABBCCDD, 2'b00, 32'h0);
    add(1, 8'h00, 32'h1,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'hAABBCC44);
    add(1, 8'h00, 32'h2,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 1, 8'd2, 32'h00000077, 2'b00, 32'h0000BEEF);
    add(1, 8'h00, 32'h2,        4'hF, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h04, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h00000077);
    add(1, 8'h00, 32'h0,        4'hF, 1, 8'd5, 32'hFFFFFFFF, 2'b00, 32'h0);
    add(1, 8'h00, 32'h0300,     4'h2, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h00, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(1, 8'h00, 32'hABCD01,   4'h1, 0, 8'd0, 32'h0,        2'b00, 32'h0);
    add(0, 8'h00, 32'h0,        4'h0, 0, 8'd0, 32'h0,        2'b00, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].he, vecs[i].hi, vecs[i].hd, st, rd, mst, mrd);
      check($sformatf("vec%0d status", i), {30'h0, st}, {30'h0, vecs[i].exp_st});
      if (!vecs[i].w) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end

    // INDEX advance behaviour across two back-to-back DATA writes.
    txn(1, 8'h00, 32'h3, 4'hF, 0, 8'd0, 32'h0, st, rd, mst, mrd);
    txn(1, 8'h04, 32'h5, 4'hF, 0, 8'd0, 32'h0, st, rd, mst, mrd);
    txn(1, 8'h04, 32'h6, 4'hF, 0, 8'd0, 32'h0, st, rd, mst, mrd);
`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INC_EN
    check("autoinc entry3", value[96 +: 32], 32'h5);
    check("autoinc entry0", value[0 +: 32], 32'h6);
    check("autoinc index", {24'h0, index}, 32'h1);
`else
    check("noinc entry3", value[96 +: 32], 32'h6);
    check("noinc index", {24'h0, index}, 32'h3);
`endif

    // Reset landing in the response cycle.
    @(negedge clk);
    valid = 1'b1; write = 1'b1; address = 8'h04; wdata = 32'hCAFEF00D; strobe = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    #1;
    check("rst_in_resp ready", {31'h0, ready}, 32'h0);
    @(posedge clk); #1;
    check("rst_in_resp ready_after", {31'h0, ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_in_resp ready_idle", {31'h0, ready}, 32'h0);
    check_state("rst_in_resp");

    // Request presented together with reset is dropped entirely.
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; write = 1'b1; address = 8'h00; wdata = 32'h3; strobe = 4'hF;
    @(posedge clk); #1;
    check("rst_with_req ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    check("rst_with_req ready_after", {31'h0, ready}, 32'h0);
    check_state("rst_with_req");

    for (int i = 0; i < 300; i++) begin
      pick = int'($urandom_range(0, 5));
      case (pick)
        0, 1:    ra = 8'h00;
        2, 3, 4: ra = 8'h04;
        default: ra = 8'($urandom);
      endcase
      if (ra[7:2] == 6'd0 && $urandom_range(0, 1) == 1)
        txn(1, ra, {$urandom, 8'($urandom_range(0, 6))} >> 8 << 8 | 32'($urandom_range(0, 6)),
            4'($urandom), $urandom_range(0, 1) == 1, 8'($urandom_range(0, 5)), $urandom,
            st, rd, mst, mrd);
      else
        txn($urandom_range(0, 1) == 1, ra, $urandom, 4'($urandom),
            $urandom_range(0, 1) == 1, 8'($urandom_range(0, 5)), $urandom,
            st, rd, mst, mrd);
      check($sformatf("rand%0d status", i), {30'h0, st}, {30'h0, mst});
      if (!write) check($sformatf("rand%0d rdata", i), rd, mrd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rggen_indirect_register_array.md
Name: rggen_indirect_register_array

Overview:
- Multi-entry successor to the single-match indirect register.
- Exposes two bus-visible words:
  - INDEX at OFFSET_ADDRESS.
  - DATA window at OFFSET_ADDRESS + BUS_WIDTH/8.
- Each DATA access reads or writes the storage entry selected by the current INDEX. Out-of-range indices are rejected with an error response.
- Sits between the rggen register bus adapter and hardware logic. Hardware gets every entry's value and a side write port.

Parameters:
- ADDRESS_WIDTH, 8, bus byte-address width.
- OFFSET_ADDRESS, 0, byte address of INDEX word; must be BUS_WIDTH/8 aligned.
- BUS_WIDTH, 32, bus data width; power of two, at least 8.
- VALUE_WIDTH, 32, width of each entry; 1..BUS_WIDTH.
- ENTRIES, 4, number of storage entries; at least 1.
- INDEX_WIDTH, 8, width of INDEX field; must be at least clog2(ENTRIES).
- INITIAL_VALUE, all zeros, VALUE_WIDTH reset value applied to every entry.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_valid, input, 1, bus request valid; held until o_ready.
- i_write, input, 1, 1 = write, 0 = read.
- i_address, input, ADDRESS_WIDTH, byte address.
- i_write_data, input, BUS_WIDTH, write data.
- i_strobe, input, BUS_WIDTH/8, byte write enables.
- o_ready, input/output: output, 1, one-cycle response strobe.
- o_status, output, 2, 00 = OKAY, 10 = SLAVE_ERROR.
- o_read_data, output, BUS_WIDTH, read data; valid with o_ready.
- o_index, output, INDEX_WIDTH, current INDEX value.
- o_value, output, ENTRIES*VALUE_WIDTH, all entries; entry k at bits [k*VALUE_WIDTH +: VALUE_WIDTH].
- i_hw_write, input, 1, hardware write enable.
- i_hw_index, input, INDEX_WIDTH, hardware write target entry.
- i_hw_data, input, VALUE_WIDTH, hardware write data.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst; all state updates on the rising edge.
- Reset values:
  - o_ready = 0, o_status = 00, o_read_data = 0, o_index = 0.
  - Every entry = INITIAL_VALUE. FSM = IDLE.
- Reset asserted mid-transaction aborts it; no response is issued.
- FSM IDLE:
  - If i_valid, decode the address, perform the access, register the response, and move to RESP.
- FSM RESP:
  - o_ready = 1 for exactly one cycle, with o_status and o_read_data, then return to IDLE.
  - Latency is request-to-response of 1 cycle; at most one transaction per 2 cycles.
- Address decode compares i_address[ADDRESS_WIDTH-1 : clog2(BUS_WIDTH/8)] against the two word addresses. Any other address:
  - Returns SLAVE_ERROR with read data 0.
  - Changes no state.
- INDEX write:
  - Byte-strobed update of the INDEX register (bits above INDEX_WIDTH ignored); status OKAY.
  - Any value is accepted, including values >= ENTRIES.
- INDEX read:
  - Returns INDEX zero-extended to BUS_WIDTH; status OKAY.
- DATA access with INDEX >= ENTRIES:
  - Returns SLAVE_ERROR with read data 0.
  - Entries unchanged.
- DATA write with a valid INDEX:
  - Byte-strobed merge into entry[INDEX]; bits at or above VALUE_WIDTH are dropped; status OKAY.
- DATA read with a valid INDEX:
  - Returns entry[INDEX] zero-extended to BUS_WIDTH; status OKAY.
- Hardware write:
  - i_hw_write with i_hw_index < ENTRIES loads the full entry on the next edge.
  - i_hw_index >= ENTRIES is ignored.
- Collision: a bus DATA write and a hardware write to the same entry in the same cycle resolve as bus wins, on strobed bytes only; unstrobed bytes take the hardware data.
- Read/hardware-write in the same cycle: the read returns the pre-write value.
- i_valid in RESP is not sampled; the request is re-evaluated in the next IDLE cycle only if it is still held. Masters drop i_valid after o_ready.

Optional Feature:
- Macro: RGGEN_INDIRECT_ARRAY_AUTO_INC_EN.
- Defined: after every OKAY DATA access (read or write), INDEX increments by 1.
  - If the incremented value equals ENTRIES, it wraps to 0.
  - An errored DATA access does not increment.
  - An INDEX write in the same transaction is impossible (separate words), so no conflict exists.
- Not defined: INDEX changes only by an INDEX write.

Test Plan:
- Reset, then read INDEX (addr 0x00) and DATA (addr 0x04) -> both OKAY, read data 0x0, 0x0; o_index = 0; o_ready high exactly 1 cycle after i_valid.
- Write INDEX = 2, write DATA 0xDEADBEEF with strobe 4'b0011, read DATA -> 0x0000BEEF OKAY; o_value entry 2 = 0x0000BEEF, other entries 0.
- Write INDEX = 4 (ENTRIES = 4), then write and read DATA -> both SLAVE_ERROR, read data 0, o_value unchanged; read 0x08 -> SLAVE_ERROR.
- Same cycle: bus DATA write 0x11223344 strobe 4'b0001 to entry 1, and hardware write 0xAABBCCDD to entry 1 -> entry 1 = 0xAABBCC44.
- With RGGEN_INDIRECT_ARRAY_AUTO_INC_EN: INDEX = 3, write DATA 0x5, write DATA 0x6 -> entry 3 = 0x5, entry 0 = 0x6, o_index = 1. Without the macro: entry 3 = 0x6, o_index = 3.
- Assert i_rst while in RESP -> o_ready stays 0, all entries back to INITIAL_VALUE, o_index = 0.
